vgachargen_mem_arb: RTL

- Sequencer/arbiter that owns port A of the ch_map and col_map BRAMs inside the character generator.
- Shares port A between two requesters: a host (APB-side) single-access port and an internal fill engine.
- The fill engine writes a constant character code and/or colour byte over a run of screen cells, wrapping at the screen end; used for clear-screen and line-fill.
- Sits between the APB register decoder and vgachargen; the video read path (port B) is untouched.

---
 rtl/vgachargen_pkg.sv | 20 ++
 rtl/vgachargen_fill_addr_gen.sv | 46 ++++
 rtl/vgachargen_mem_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the character generator's port-A arbiter.
// The optional fill-abort feature is enabled with VGACHARGEN_FILL_ABORT_EN.
package vgachargen_pkg;

    localparam int CH_MAP_ADDR_WIDTH  = 12;
    localparam int COL_MAP_ADDR_WIDTH = 12;
    localparam int SCREEN_CELLS       = 2400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        MAP_CH  = 1'b0,
        MAP_COL = 1'b1
    } map_sel_e;

endpackage

// File: rtl/vgachargen_fill_addr_gen.sv
// Fill cell walker: index counter, remaining-cell count, single-wrap adder and
// last-cell flag. Base and length are reduced/clamped when loaded.
module vgachargen_fill_addr_gen #(
    parameter int SCREEN_CELLS = vgachargen_pkg::SCREEN_CELLS,
    parameter int ADDR_W       = vgachargen_pkg::CH_MAP_ADDR_WIDTH
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(SCREEN_CELLS);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   base_ext;
    logic [ADDR_W:0]   sum;

    assign base_ext = {1'b0, base};
    assign sum      = {1'b0, base_q} + {1'b0, idx};
    // base_q and idx are both below CELLS, so one subtraction always suffices
    assign addr     = (sum >= CELLS) ? ADDR_W'(sum - CELLS) : sum[ADDR_W-1:0];
    assign last     = (remaining == (ADDR_W + 1)'(1));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            base_q    <= '0;
            idx       <= '0;
            remaining <= '0;
        end else if (load) begin
            base_q    <= (base_ext >= CELLS) ? ADDR_W'(base_ext - CELLS) : base;
            idx       <= '0;
            remaining <= (len > CELLS) ? CELLS : len;
        end else if (advance) begin
            idx       <= idx + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
        end
    end

endmodule

// File: rtl/vgachargen_mem_arb.sv
// Port-A owner for ch_map/col_map: host single accesses interleaved with a
// constant-fill engine. Optional abort input via VGACHARGEN_FILL_ABORT_EN.
module vgachargen_mem_arb #(
    parameter int SCREEN_CELLS = vgachargen_pkg::SCREEN_CELLS,
    parameter int ADDR_W       = vgachargen_pkg::CH_MAP_ADDR_WIDTH,
    parameter int DATA_W       = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic              host_sel_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    input  logic              fill_start_i,
    input  logic [ADDR_W-1:0] fill_base_i,
    input  logic [ADDR_W:0]   fill_len_i,
    input  logic [1:0]        fill_mask_i,
    input  logic [DATA_W-1:0] fill_ch_i,
    input  logic [DATA_W-1:0] fill_col_i,
`ifdef VGACHARGEN_FILL_ABORT_EN
    input  logic              fill_abort_i,
    output logic              fill_aborted_o,
`endif
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic [ADDR_W-1:0] ch_map_addr_o,
    output logic [DATA_W-1:0] ch_map_data_o,
    output logic              ch_map_wen_o,
    input  logic [DATA_W-1:0] ch_map_rdata_i,
    output logic [ADDR_W-1:0] col_map_addr_o,
    output logic [DATA_W-1:0] col_map_data_o,
    output logic              col_map_wen_o,
    input  logic [DATA_W-1:0] col_map_rdata_i
);

    import vgachargen_pkg::*;

    arb_state_e        state;
    map_sel_e          rd_sel;
    logic [1:0]        mask_q;
    logic [DATA_W-1:0] ch_q;
    logic [DATA_W-1:0] col_q;
    logic              last_fill;
    logic              host_slot;
    logic              fill_slot;
    logic              abort;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_last;

`ifdef VGACHARGEN_FILL_ABORT_EN
    assign abort = fill_abort_i && (state == FILL);

    // Pulses in the DONE cycle that follows an aborted FILL cycle
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) fill_aborted_o <= 1'b0;
        else          fill_aborted_o <= abort;
    end
`else
    assign abort = 1'b0;
`endif

    vgachargen_fill_addr_gen #(
        .SCREEN_CELLS(SCREEN_CELLS),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .arstn_i(arstn_i),
        .load   ((state == IDLE) && fill_start_i),
        .base   (fill_base_i),
        .len    (fill_len_i),
        .advance(fill_slot),
        .addr   (fill_addr),
        .last   (fill_last)
    );

    // During FILL the host wins only if fill took the previous slot
    always_comb begin
        host_slot = 1'b0;
        fill_slot = 1'b0;
        if (state == FILL) begin
            host_slot = host_req_i && (last_fill || abort);
            fill_slot = !host_slot && !abort;
        end else begin
            host_slot = host_req_i;
        end
    end

    assign host_gnt_o = host_slot;

    always_comb begin
        ch_map_addr_o  = '0;
        ch_map_data_o  = '0;
        ch_map_wen_o   = 1'b0;
        col_map_addr_o = '0;
        col_map_data_o = '0;
        col_map_wen_o  = 1'b0;
        if (fill_slot) begin
            ch_map_addr_o  = fill_addr;
            ch_map_data_o  = ch_q;
            ch_map_wen_o   = mask_q[0];
            col_map_addr_o = fill_addr;
            col_map_data_o = col_q;
            col_map_wen_o  = mask_q[1];
        end else if (host_slot) begin
            if (map_sel_e'(host_sel_i) == MAP_COL) begin
                col_map_addr_o = host_addr_i;
                col_map_data_o = host_wdata_i;
                col_map_wen_o  = host_we_i;
            end else begin
                ch_map_addr_o  = host_addr_i;
                ch_map_data_o  = host_wdata_i;
                ch_map_wen_o   = host_we_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= IDLE;
            fill_busy_o <= 1'b0;
            fill_done_o <= 1'b0;
            mask_q      <= '0;
            ch_q        <= '0;
            col_q       <= '0;
            last_fill   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fill_done_o <= 1'b0;
                    last_fill   <= 1'b0;
                    if (fill_start_i) begin
                        mask_q      <= fill_mask_i;
                        ch_q        <= fill_ch_i;
                        col_q       <= fill_col_i;
                        fill_busy_o <= 1'b1;
                        if ((fill_len_i != '0) && (fill_mask_i != 2'b00)) begin
                            state <= FILL;
                        end else begin
                            state       <= DONE;
                            fill_done_o <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_slot)      last_fill <= 1'b1;
                    else if (host_slot) last_fill <= 1'b0;
                    if (abort || (fill_slot && fill_last)) begin
                        state       <= DONE;
                        fill_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    fill_busy_o <= 1'b0;
                    fill_done_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    fill_busy_o <= 1'b0;
                    fill_done_o <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the grant; steer it with the latched select
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            host_rvalid_o <= 1'b0;
            rd_sel        <= MAP_CH;
        end else begin
            host_rvalid_o <= host_slot && !host_we_i;
            if (host_slot && !host_we_i) rd_sel <= map_sel_e'(host_sel_i);
        end
    end

    assign host_rdata_o = !host_rvalid_o ? '0 :
                          (rd_sel == MAP_COL) ? col_map_rdata_i : ch_map_rdata_i;

endmodule
